// File: rtl/float_sample_drain_pkg.sv
// ---------------------------------------------------------------------------
// float_sample_drain_pkg
//   Shared types and constants for the batch filter's output drain.
//   floatType    : IEEE-754 single-precision layout (sign/exp/mant)
//   FLT_EXP_W, FLT_MANT_W, FLT_EXP_BIAS : field widths and exponent bias
//   FLT_W        : total width of floatType
//   fix_limit()  : largest magnitude a signed fixed-point word of a given
//                  width can hold for the requested sign
// ---------------------------------------------------------------------------
package float_sample_drain_pkg;

    localparam int FLT_EXP_W    = 8;
    localparam int FLT_MANT_W   = 23;
    localparam int FLT_EXP_BIAS = 127;
    localparam int FLT_W        = 1 + FLT_EXP_W + FLT_MANT_W;

    typedef struct packed {
        logic                  sign;
        logic [FLT_EXP_W-1:0]  exp;
        logic [FLT_MANT_W-1:0] mant;
    } floatType;

    // Negative words reach one further than positive ones (two's complement).
    function automatic logic [63:0] fix_limit(input int out_w, input logic neg);
        logic [63:0] base_v;
        base_v = 64'd1 << (out_w - 1);
        if (neg) begin
            fix_limit = base_v;
        end else begin
            fix_limit = base_v - 64'd1;
        end
    endfunction

endpackage

// File: rtl/float_sample_drain_float_to_fixed.sv
// ---------------------------------------------------------------------------
// float_to_fixed
//   Combinational floatType -> saturated signed fixed point (OUT_W bits,
//   FRAC fractional bits).
//   f     : input float sample
//   value : converted two's-complement word
//   sat   : conversion saturated, or the input was Inf/NaN
// Build option: DRAIN_ROUND_EN selects round-half-away-from-zero instead of
// truncation toward zero.
// ---------------------------------------------------------------------------
module float_to_fixed
    import float_sample_drain_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int FRAC  = 8
) (
    input  floatType         f,
    output logic [OUT_W-1:0] value,
    output logic             sat
);

    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] ONE_W   = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [63:0] sig_s;
    logic [63:0] mag_s;
    logic        ovf_s;
    int          sh_s;
    int          rsh_s;

    // Classify the input, scale the significand by 2^(exp-BIAS+FRAC) and clamp.
    always_comb begin
        value = {OUT_W{1'b0}};
        sat   = 1'b0;
        mag_s = 64'd0;
        ovf_s = 1'b0;
        rsh_s = 0;
        sig_s = {{(64-FLT_MANT_W-1){1'b0}}, 1'b1, f.mant};
        // Net left shift of the integer significand {1,mant}.
        sh_s  = int'(f.exp) - FLT_EXP_BIAS - FLT_MANT_W + FRAC;

        if (f.exp == {FLT_EXP_W{1'b0}}) begin
            // zero and denormals flush to zero
            value = {OUT_W{1'b0}};
        end else if (f.exp == {FLT_EXP_W{1'b1}}) begin
            sat = 1'b1;
            if (f.mant == {FLT_MANT_W{1'b0}}) begin
                value = f.sign ? NEG_MIN : POS_MAX;
            end else begin
                value = {OUT_W{1'b0}};
            end
        end else begin
            if (sh_s >= OUT_W) begin
                // significand >= 1, so the result is at least 2^OUT_W
                ovf_s = 1'b1;
            end else if (sh_s >= 0) begin
                mag_s = sig_s << sh_s;
            end else if (sh_s < -(FLT_MANT_W + 2)) begin
                // below half an LSB even after rounding
                mag_s = 64'd0;
            end else begin
                rsh_s = -sh_s;
`ifdef DRAIN_ROUND_EN
                mag_s = (sig_s + (64'd1 << (rsh_s - 1))) >> rsh_s;
`else
                mag_s = sig_s >> rsh_s;
`endif
            end

            if (ovf_s || (mag_s > fix_limit(OUT_W, f.sign))) begin
                sat   = 1'b1;
                value = f.sign ? NEG_MIN : POS_MAX;
            end else if (f.sign) begin
                value = ~mag_s[OUT_W-1:0] + ONE_W;
            end else begin
                value = mag_s[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/float_sample_drain.sv
// ---------------------------------------------------------------------------
// float_sample_drain
//   Decimates the batch filter's float result stream, converts kept samples
//   to saturated fixed point and queues them in a first-word-fall-through
//   FIFO for a valid/ready consumer.
//   clk, rst   : clock, synchronous active-high reset
//   in         : float sample (floatType bits), in_valid qualifies it
//   out_data   : head-of-FIFO word, out_valid when FIFO not empty
//   out_ready  : consumer pops on out_valid & out_ready
//   overflow   : sticky, a kept sample was dropped on a full FIFO
//   sat        : sticky, a conversion saturated or saw Inf/NaN
//   level      : FIFO occupancy
// Build option: DRAIN_ROUND_EN (see float_to_fixed) changes rounding only.
// ---------------------------------------------------------------------------
module float_sample_drain
    import float_sample_drain_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int OUT_W      = 16,
    parameter int FRAC       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLT_W-1:0]              in,
    input  logic                          in_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          sat,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    floatType          in_f_s;
    logic [OUT_W-1:0]  conv_value_s;
    logic              conv_sat_s;

    logic [PW-1:0]     phase_r;
    logic              conv_valid_r;
    logic [OUT_W-1:0]  conv_data_r;
    logic [OUT_W-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              out_valid_r;
    logic [OUT_W-1:0]  out_data_r;
    logic              overflow_r;
    logic              sat_r;

    logic              keep_s;
    logic              pop_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic [AW-1:0]     next_rd_s;
    logic [LW-1:0]     next_level_s;
    logic [OUT_W-1:0]  next_head_s;

    assign in_f_s = in;

    float_to_fixed #(
        .OUT_W (OUT_W),
        .FRAC  (FRAC)
    ) u_conv (
        .f     (in_f_s),
        .value (conv_value_s),
        .sat   (conv_sat_s)
    );

    // FIFO control and the head word that will be visible after this edge.
    always_comb begin
        keep_s  = in_valid && (phase_r == {PW{1'b0}});
        pop_s   = out_valid_r && out_ready;
        full_s  = (level_r == LW'(FIFO_DEPTH));
        push_s  = conv_valid_r && (!full_s || pop_s);
        drop_s  = conv_valid_r && full_s && !pop_s;

        if (pop_s) begin
            next_rd_s = rd_ptr_r + AW'(1);
        end else begin
            next_rd_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   next_level_s = level_r + LW'(1);
            2'b01:   next_level_s = level_r - LW'(1);
            default: next_level_s = level_r;
        endcase

        // The new head may be the word being written on this very edge.
        if (push_s && (wr_ptr_r == next_rd_s)) begin
            next_head_s = conv_data_r;
        end else begin
            next_head_s = mem_r[next_rd_s];
        end
    end

    // Phase counter, conversion stage, FIFO pointers, registered outputs, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r      <= {PW{1'b0}};
            conv_valid_r <= 1'b0;
            conv_data_r  <= {OUT_W{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            out_valid_r  <= 1'b0;
            out_data_r   <= {OUT_W{1'b0}};
            overflow_r   <= 1'b0;
            sat_r        <= 1'b0;
        end else begin
            if (in_valid) begin
                if (phase_r == PW'(DECIM - 1)) begin
                    phase_r <= {PW{1'b0}};
                end else begin
                    phase_r <= phase_r + PW'(1);
                end
            end
            conv_valid_r <= keep_s;
            if (keep_s) begin
                conv_data_r <= conv_value_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r    <= next_rd_s;
            level_r     <= next_level_s;
            out_valid_r <= (next_level_s != {LW{1'b0}});
            out_data_r  <= (next_level_s != {LW{1'b0}}) ? next_head_s : {OUT_W{1'b0}};
            overflow_r  <= overflow_r | drop_s;
            sat_r       <= sat_r | (keep_s & conv_sat_s);
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= conv_data_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign sat       = sat_r;
    assign level     = level_r;

endmodule

// File: tb/tb_float_sample_drain.sv
module tb_float_sample_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT a: DECIM=1, FIFO_DEPTH=4
    logic [31:0] in_a = 32'd0;
    logic        in_valid_a = 1'b0;
    logic        out_ready_a = 1'b0;
    logic [15:0] out_data_a;
    logic        out_valid_a;
    logic        overflow_a;
    logic        sat_a;
    logic [2:0]  level_a;

    // DUT b: DECIM=4, FIFO_DEPTH=8
    logic [31:0] in_b = 32'd0;
    logic        in_valid_b = 1'b0;
    logic        out_ready_b = 1'b0;
    logic [15:0] out_data_b;
    logic        out_valid_b;
    logic        overflow_b;
    logic        sat_b;
    logic [3:0]  level_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    float_sample_drain #(.DECIM(1), .OUT_W(16), .FRAC(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .in_valid(in_valid_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .overflow(overflow_a), .sat(sat_a), .level(level_a)
    );

    float_sample_drain #(.DECIM(4), .OUT_W(16), .FRAC(8), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .overflow(overflow_b), .sat(sat_b), .level(level_b)
    );

    typedef struct {
        string       nm;
        logic [31:0] f;
        logic [15:0] d;
        logic        s;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // float encodings of 1.0 .. 8.0
    logic [31:0] flt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pop one word from dut a, checking the head first (called at a negedge).
    task automatic drain_a(input string name, input logic [15:0] exp);
        chk({name, "_valid"}, {31'd0, out_valid_a}, 32'd1);
        chk({name, "_data"}, {16'd0, out_data_a}, {16'd0, exp});
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
    endtask

    task automatic drain_b(input string name, input logic [15:0] exp);
        chk({name, "_valid"}, {31'd0, out_valid_b}, 32'd1);
        chk({name, "_data"}, {16'd0, out_data_b}, {16'd0, exp});
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
    endtask

    // Push flt[first..last] on consecutive cycles into dut a.
    task automatic push_a(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            in_a = flt[k];
            in_valid_a = 1'b1;
            @(negedge clk);
        end
        in_valid_a = 1'b0;
    endtask

    initial begin
        flt[0] = 32'h3F80_0000; flt[1] = 32'h4000_0000;
        flt[2] = 32'h4040_0000; flt[3] = 32'h4080_0000;
        flt[4] = 32'h40A0_0000; flt[5] = 32'h40C0_0000;
        flt[6] = 32'h40E0_0000; flt[7] = 32'h4100_0000;

        vecs[0]  = '{"p1_5",     32'h3FC0_0000, 16'h0180, 1'b0};
        vecs[1]  = '{"m2_25",    32'hC010_0000, 16'hFDC0, 1'b0};
        vecs[2]  = '{"p1000",    32'h447A_0000, 16'h7FFF, 1'b1};
        vecs[3]  = '{"m1000",    32'hC47A_0000, 16'h8000, 1'b1};
        vecs[4]  = '{"nan",      32'h7FC0_0000, 16'h0000, 1'b1};
        vecs[5]  = '{"pinf",     32'h7F80_0000, 16'h7FFF, 1'b1};
        vecs[6]  = '{"minf",     32'hFF80_0000, 16'h8000, 1'b1};
        vecs[7]  = '{"zero",     32'h0000_0000, 16'h0000, 1'b0};
        vecs[8]  = '{"denorm",   32'h0000_0001, 16'h0000, 1'b0};
        vecs[9]  = '{"m128",     32'hC300_0000, 16'h8000, 1'b0};
        vecs[10] = '{"p128",     32'h4300_0000, 16'h7FFF, 1'b1};
        vecs[11] = '{"max_exact",32'h42FF_FE00, 16'h7FFF, 1'b0};
`ifdef DRAIN_ROUND_EN
        vecs[12] = '{"p_1_5lsb", 32'h3BC0_0000, 16'h0002, 1'b0};
        vecs[13] = '{"m_1_5lsb", 32'hBBC0_0000, 16'hFFFE, 1'b0};
        vecs[14] = '{"half_lsb", 32'h3B00_0000, 16'h0001, 1'b0};
        vecs[15] = '{"rnd_carry",32'h42FF_FF00, 16'h7FFF, 1'b1};
`else
        vecs[12] = '{"p_1_5lsb", 32'h3BC0_0000, 16'h0001, 1'b0};
        vecs[13] = '{"m_1_5lsb", 32'hBBC0_0000, 16'hFFFF, 1'b0};
        vecs[14] = '{"half_lsb", 32'h3B00_0000, 16'h0000, 1'b0};
        vecs[15] = '{"rnd_carry",32'h42FF_FF00, 16'h7FFF, 1'b0};
`endif

        // Reset state of both instances
        do_reset();
        @(negedge clk);
        chk("rst_valid_a", {31'd0, out_valid_a}, 32'd0);
        chk("rst_data_a",  {16'd0, out_data_a},  32'd0);
        chk("rst_level_a", {29'd0, level_a},     32'd0);
        chk("rst_ovf_a",   {31'd0, overflow_a},  32'd0);
        chk("rst_sat_a",   {31'd0, sat_a},       32'd0);
        chk("rst_valid_b", {31'd0, out_valid_b}, 32'd0);
        chk("rst_level_b", {28'd0, level_b},     32'd0);

        // Conversion table: single pulse, latency 2, value and sticky sat
        for (int i = 0; i < NV; i++) begin
            do_reset();
            in_a = vecs[i].f;
            in_valid_a = 1'b1;
            @(negedge clk);
            in_valid_a = 1'b0;
            chk({vecs[i].nm, "_lat1"}, {31'd0, out_valid_a}, 32'd0);
            @(negedge clk);
            chk({vecs[i].nm, "_valid"}, {31'd0, out_valid_a}, 32'd1);
            chk({vecs[i].nm, "_data"},  {16'd0, out_data_a},  {16'd0, vecs[i].d});
            chk({vecs[i].nm, "_sat"},   {31'd0, sat_a},       {31'd0, vecs[i].s});
            out_ready_a = 1'b1;
            @(negedge clk);
            out_ready_a = 1'b0;
            chk({vecs[i].nm, "_empty"}, {31'd0, out_valid_a}, 32'd0);
        end

        // Decimation by 4 with in_valid gaps: keep 1.0 and 5.0 only
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_b = flt[k];
            in_valid_b = 1'b1;
            @(negedge clk);
            in_valid_b = 1'b0;
            if ((k % 3) == 1) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("decim_level", {28'd0, level_b}, 32'd2);
        drain_b("decim_0", 16'h0100);
        drain_b("decim_1", 16'h0500);
        chk("decim_empty", {31'd0, out_valid_b}, 32'd0);

        // Overflow: 5 kept samples into depth-4 FIFO with no pops
        do_reset();
        push_a(0, 4);
        @(negedge clk);
        @(negedge clk);
        chk("ovf_level", {29'd0, level_a}, 32'd4);
        chk("ovf_flag",  {31'd0, overflow_a}, 32'd1);
        // out_data must hold while stalled
        @(negedge clk);
        chk("ovf_hold", {16'd0, out_data_a}, 32'h0100);
        drain_a("ovf_0", 16'h0100);
        drain_a("ovf_1", 16'h0200);
        drain_a("ovf_2", 16'h0300);
        drain_a("ovf_3", 16'h0400);
        chk("ovf_empty", {31'd0, out_valid_a}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow_a}, 32'd1);
        // pop with empty FIFO is ignored
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("pop_empty_level", {29'd0, level_a}, 32'd0);

        // Full FIFO, write and pop on the same edge
        do_reset();
        push_a(0, 3);
        @(negedge clk);
        chk("pp_full", {29'd0, level_a}, 32'd4);
        in_a = flt[4];
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("pp_head", {16'd0, out_data_a}, 32'h0100);
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("pp_level", {29'd0, level_a}, 32'd4);
        chk("pp_ovf", {31'd0, overflow_a}, 32'd0);
        drain_a("pp_0", 16'h0200);
        drain_a("pp_1", 16'h0300);
        drain_a("pp_2", 16'h0400);
        drain_a("pp_3", 16'h0500);

        // Reset mid-stream: FIFO, in-flight sample, flags and phase all cleared
        do_reset();
        in_b = flt[0]; in_valid_b = 1'b1;          // kept, phase -> 1
        in_a = 32'h447A_0000; in_valid_a = 1'b1;   // saturating sample
        @(negedge clk);
        in_b = flt[1];
        in_a = flt[1];
        @(negedge clk);                            // phase b -> 2, a has data in flight
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid_a", {31'd0, out_valid_a}, 32'd0);
        chk("mrst_data_a",  {16'd0, out_data_a},  32'd0);
        chk("mrst_level_a", {29'd0, level_a},     32'd0);
        chk("mrst_sat_a",   {31'd0, sat_a},       32'd0);
        chk("mrst_level_b", {28'd0, level_b},     32'd0);
        @(negedge clk);
        chk("mrst_flush_a", {31'd0, out_valid_a}, 32'd0);
        // first sample after reset must be kept (phase restarted at 0)
        in_b = flt[2]; in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        @(negedge clk);
        drain_b("mrst_phase", 16'h0300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
